// File: rtl/l1_data_cache.sv
// rtl/l1_data_cache.sv - direct-mapped write-back L1 data cache with 32-byte lines
//
// Purpose: zero-wait-state hits from an IDLE state; misses write back a dirty
// victim (WRITEBACK), fill the line (ALLOCATE), then retry the request as a hit.
//
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   cmem_read/cmem_write       CPU request (both high is a write)
//   cmem_address/byte_enable   request address and store byte lanes
//   cmem_wdata/cmem_rdata      store data / load word (full 32 bits)
//   cmem_resp                  completion strobe, same cycle as a hit
//   pmem_read/pmem_write       line fill / writeback request to next level
//   pmem_address/pmem_wdata    line address and victim line
//   pmem_resp/pmem_rdata       next-level completion and fill line
//   l1d_hit                    performance strobe, equal to cmem_resp

module l1_data_cache #(
    parameter int s_index = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmem_read,
    input  logic         cmem_write,
    input  logic [31:0]  cmem_address,
    input  logic [3:0]   cmem_byte_enable,
    input  logic [31:0]  cmem_wdata,
    output logic         cmem_resp,
    output logic [31:0]  cmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic         l1d_hit
);

    localparam int num_sets = 1 << s_index;
    localparam int tag_w    = 27 - s_index;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [num_sets-1:0] valid_q;
    logic [num_sets-1:0] dirty_q;
    logic [tag_w-1:0]    tag_q  [num_sets];
    logic [255:0]        line_q [num_sets];

    // The missing request is captured when leaving IDLE so the fill still lands
    // in the right set even if the CPU drops or changes its request mid-miss.
    logic [tag_w-1:0]    miss_tag_q;
    logic [s_index-1:0]  miss_index_q;

    logic [tag_w-1:0]    req_tag;
    logic [s_index-1:0]  req_index;
    logic [2:0]          req_word;
    logic                req;
    logic                tag_match;
    logic                store_hit;
    logic [255:0]        cur_line;
    logic [31:0]         cur_word;
    logic [31:0]         merged_word;
    logic                unused_addr_bits;

    assign req_tag          = cmem_address[31:5+s_index];
    assign req_index        = cmem_address[4+s_index:5];
    assign req_word         = cmem_address[4:2];
    assign unused_addr_bits = ^cmem_address[1:0];

    assign req       = cmem_read | cmem_write;
    assign tag_match = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign cur_line  = line_q[req_index];
    assign cur_word  = cur_line[{req_word, 5'b0} +: 32];
    assign cmem_rdata = cur_word;

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (cmem_byte_enable[b]) begin
                merged_word[b*8 +: 8] = cmem_wdata[b*8 +: 8];
            end
        end
    end

    // cmem_resp is already gated by reset and state, so it doubles as the hit qualifier.
    assign store_hit = cmem_resp && cmem_write;
    assign l1d_hit   = cmem_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cmem_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 256'd0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (tag_match) begin
                        cmem_resp = 1'b1;
                    end else if (valid_q[req_index] && dirty_q[req_index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_index_q], miss_index_q, 5'b0};
                pmem_wdata   = line_q[miss_index_q];
                if (pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag_q, miss_index_q, 5'b0};
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset silences the CPU and memory interfaces in the reset cycle itself.
        if (reset) begin
            state_next   = IDLE;
            cmem_resp    = 1'b0;
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = 32'd0;
            pmem_wdata   = 256'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && req && !tag_match) begin
            miss_tag_q   <= req_tag;
            miss_index_q <= req_index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[req_index] <= 1'b1;
        end else if (state == ALLOCATE && pmem_resp) begin
            valid_q[miss_index_q] <= 1'b1;
            dirty_q[miss_index_q] <= 1'b0;
        end
    end

    // Tags and line data are deliberately not cleared by reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (store_hit) begin
                line_q[req_index][{req_word, 5'b0} +: 32] <= merged_word;
            end else if (state == ALLOCATE && pmem_resp) begin
                line_q[miss_index_q] <= pmem_rdata;
                tag_q[miss_index_q]  <= miss_tag_q;
            end
        end
    end

endmodule

// File: doc/l1_data_cache.md
L1_DATA_CACHE -- requirements
Module: l1_data_cache

Interface
REQ-001 SHALL have parameter s_index, default 3, meaning set-index width (2**s_index sets, direct-mapped, 32-byte lines).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmem_read / cmem_write  input  1  CPU-side read / write request.
REQ-005 SHALL have ports cmem_address  input  32, cmem_byte_enable  input  4, cmem_wdata  input  32  request address, store byte lanes, store data.
REQ-006 SHALL have ports cmem_resp  output  1, cmem_rdata  output  32  completion strobe and load data.
REQ-007 SHALL have ports pmem_read / pmem_write  output  1, pmem_address  output  32, pmem_wdata  output  256  line-fill / writeback requests to next level.
REQ-008 SHALL have ports pmem_resp  input  1, pmem_rdata  input  256  next-level completion and fill line.
REQ-009 SHALL have port l1d_hit  output  1  performance strobe, high in any cycle a request completes as a hit.

Function
REQ-010 Address split: tag = addr[31:5+s_index], index = addr[4+s_index:5], word = addr[4:2]; addr[1:0] ignored.
REQ-011 Per set: valid bit, dirty bit, tag, 256-bit line; arrays read asynchronously, written on clk edge.
REQ-012 FSM states: IDLE, WRITEBACK, ALLOCATE; reset state IDLE.
REQ-013 IDLE, request present, valid & tag match (hit): cmem_resp=1 combinationally in the same cycle; l1d_hit=1; zero-wait-state.
REQ-014 Read hit: cmem_rdata = line word selected by word field, full 32 bits (byte extraction is the CPU's job).
REQ-015 Write hit: at that cycle's edge, bytes of cmem_wdata whose cmem_byte_enable bit is 1 merge into the selected word; other bytes unchanged; dirty set to 1.
REQ-016 cmem_read and cmem_write both high SHALL be treated as a write.
REQ-017 IDLE miss, victim valid & dirty: next state WRITEBACK; otherwise next state ALLOCATE; cmem_resp=0, l1d_hit=0.
REQ-018 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; held stable until pmem_resp; on pmem_resp go ALLOCATE.
REQ-019 ALLOCATE: pmem_read=1, pmem_address={request tag, index, 5'b0}; held until pmem_resp; on pmem_resp write pmem_rdata to line, set valid=1, dirty=0, tag=request tag, go IDLE.
REQ-020 After ALLOCATE, the retried request SHALL hit in IDLE on the following cycle (miss latency = fill cycles + 1, plus writeback cycles if dirty).
REQ-021 cmem_resp SHALL never assert in WRITEBACK or ALLOCATE; pmem_read and pmem_write SHALL never be high together; both 0 in IDLE.
REQ-022 CPU holds request and address stable until cmem_resp; a request dropped mid-miss still completes the in-flight pmem transaction and the fill.
REQ-023 pmem_resp while IDLE SHALL be ignored.
REQ-024 l1d_hit SHALL equal cmem_resp (misses counted only by their initial IDLE cycle being non-hit).
REQ-025 No request in IDLE: all outputs 0 except cmem_rdata (don't-care); no state change.

Reset
REQ-026 reset=1 at an edge: state->IDLE, all valid and dirty bits->0; tags/data not cleared.
REQ-027 During and one cycle after reset: cmem_resp=0, l1d_hit=0, pmem_read=0, pmem_write=0.
REQ-028 Reset during WRITEBACK/ALLOCATE SHALL abandon the transaction with no array update; pmem_read/pmem_write low the cycle after.
REQ-029 After reset, every first access to a set SHALL miss with no writeback.

Verification
REQ-030 After reset, read 0x0000_0040 -> ALLOCATE at pmem_address 0x0000_0040; pmem_resp after 5 cycles with word1=0xDEADBEEF; read of 0x0000_0044 then hits, cmem_rdata=0xDEADBEEF, l1d_hit=1 same cycle.
REQ-031 Write hit 0x0000_0044, byte_enable 4'b0011, wdata 0x1234_5678 -> next read returns 0xDEAD_5678, resp same cycle, dirty=1.
REQ-032 Then read 0x0000_0140 (same index 2, different tag) -> WRITEBACK to 0x0000_0040 carrying 0xDEAD_5678 in word1, then ALLOCATE at 0x0000_0140, then hit.
REQ-033 Clean conflict miss -> ALLOCATE only, pmem_write never asserted.
REQ-034 Assert reset while pmem_read high in ALLOCATE -> pmem_read 0 next cycle; prior-resident address re-read misses.
REQ-035 Random read/write stream vs. byte-accurate memory model -> all load data match; pmem_read&pmem_write never both high.
